// File: rtl/logic_gate_pkg.sv
// Shared types for the logic gate unit: operation select encoding.
// No logic; pure declarations.
// Imported by the interface, core and top.
package logic_gate_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NOT  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_PASS = 3'd7
  } op_t;

endpackage

// File: rtl/logic_gate_if.sv
// Bus bundle for the logic gate unit: input handshake, operands, output handshake, status.
// No logic; master drives operands/handshake, slave returns result and status.
// Backpressure carried by in_ready/out_ready.
interface logic_gate_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  import logic_gate_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [OP_W-1:0]     op;
  logic                acc_en;
  logic                acc_clear;
  logic [WIDTH-1:0]    a;
  logic [WIDTH-1:0]    b;
  logic                out_valid;
  logic                out_ready;
  logic [WIDTH-1:0]    result;
  logic                zero;
  logic                parity;
  logic [WIDTH-1:0]    acc;
  logic [CNT_W-1:0]    count;

  modport master (
    output in_valid, op, acc_en, acc_clear, a, b, out_ready,
    input  in_ready, out_valid, result, zero, parity, acc, count
  );

  modport slave (
    input  in_valid, op, acc_en, acc_clear, a, b, out_ready,
    output in_ready, out_valid, result, zero, parity, acc, count
  );

endinterface

// File: rtl/logic_gate_core.sv
// Combinational bitwise operator: value = op(a, b) plus zero and parity of the value.
// Latency 0 (purely combinational).
// No flow control; the caller decides when the value is captured.
module logic_gate_core
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_t              op,
  output logic [WIDTH-1:0] value,
  output logic             zero,
  output logic             parity
);

  // Select the bitwise operation; every op works lane-by-lane with no carries.
  always_comb begin
    value = a;
    case (op)
      OP_AND:  value = a & b;
      OP_OR:   value = a | b;
      OP_NOT:  value = ~a;
      OP_NAND: value = ~(a & b);
      OP_NOR:  value = ~(a | b);
      OP_XOR:  value = a ^ b;
      OP_XNOR: value = ~(a ^ b);
      OP_PASS: value = a;
      default: value = a;
    endcase
  end

  assign zero   = (value == '0);
  assign parity = ^value;

endmodule

// File: rtl/logic_gate_unit.sv
// Registered bitwise operator with optional accumulate chaining, status flags and accept counter.
// Latency 1 cycle from accept to out_valid; sustains one transaction per cycle.
// One-deep output register: in_ready drops only while a result is held and out_ready is low.
module logic_gate_unit
  import logic_gate_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter int               CNT_W    = 16,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic        clk,
  input  logic        reset,
  logic_gate_if.slave bus
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q,    result_d;
  logic             zero_q,      zero_d;
  logic             parity_q,    parity_d;
  logic [WIDTH-1:0] acc_q,       acc_d;
  logic [CNT_W-1:0] count_q,     count_d;

  logic             in_ready;
  logic             accept;
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] core_value;
  logic             core_zero;
  logic             core_parity;

  // The slot is free when empty or when its current result leaves this cycle.
  assign in_ready  = ~out_valid_q | bus.out_ready;
  assign accept    = bus.in_valid & in_ready;
  assign operand_b = bus.acc_en ? acc_q : bus.b;

  logic_gate_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a      (bus.a),
    .b      (operand_b),
    .op     (op_t'(bus.op)),
    .value  (core_value),
    .zero   (core_zero),
    .parity (core_parity)
  );

  // Next-state: load on accept, drain on consume, accumulator and counter updates.
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    parity_d    = parity_q;
    acc_d       = acc_q;
    count_d     = count_q;

    if (accept) begin
      out_valid_d = 1'b1;
      result_d    = core_value;
      zero_d      = core_zero;
      parity_d    = core_parity;
      count_d     = count_q + CNT_W'(1);
      if (bus.acc_en) begin
        acc_d = core_value;
      end
    end else if (out_valid_q && bus.out_ready) begin
      // Consumed with nothing new: flags and result keep their stale values.
      out_valid_d = 1'b0;
    end

    // Clear wins over an accumulate load; the result above already used the old acc.
    if (bus.acc_clear) begin
      acc_d = ACC_INIT;
    end
  end

  // State registers with synchronous reset that discards any pending result.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      parity_q    <= 1'b0;
      acc_q       <= ACC_INIT;
      count_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      parity_q    <= parity_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.parity    = parity_q;
  assign bus.acc       = acc_q;
  assign bus.count     = count_q;

endmodule

// File: tb/tb_logic_gate_unit.sv
// Bench for logic_gate_unit: an 8-bit instance (4-bit counter) and a 1-bit instance (ACC_INIT=1).
// Reference model works per bit from gate truth tables and tracks handshake state abstractly.
module tb_logic_gate_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic_gate_if #(.WIDTH(8), .CNT_W(4))  if8 ();
  logic_gate_if #(.WIDTH(1), .CNT_W(16)) if1 ();

  logic_gate_unit #(.WIDTH(8), .CNT_W(4), .ACC_INIT(8'h00)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (if8)
  );

  logic_gate_unit #(.WIDTH(1), .CNT_W(16), .ACC_INIT(1'b1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1)
  );

  int nvec = 0;
  int nerr = 0;

  // Gate truth tables, bit index {a,b}; ops in encoding order AND..PASS.
  logic [3:0] tt [8] = '{4'b1000, 4'b1110, 4'b0011, 4'b0111,
                         4'b0001, 4'b0110, 4'b1001, 4'b1100};

  // Model state of the 8-bit instance.
  logic       m_ov;
  logic [7:0] m_res;
  logic       m_zero, m_par;
  logic [7:0] m_acc;
  logic [3:0] m_cnt;

  // Stimulus currently presented to the 8-bit instance.
  logic       s_iv, s_or, s_ae, s_ac;
  logic [2:0] s_op;
  logic [7:0] s_a, s_b;

  function automatic logic [7:0] ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [3:0] row;
    row = tt[op];
    for (int i = 0; i < 8; i++) r[i] = row[{a[i], b[i]}];
    return r;
  endfunction

  task automatic idle_inputs();
    if8.in_valid = 1'b0; if8.out_ready = 1'b0; if8.op = 3'd0; if8.acc_en = 1'b0;
    if8.acc_clear = 1'b0; if8.a = 8'h00; if8.b = 8'h00;
    if1.in_valid = 1'b0; if1.out_ready = 1'b0; if1.op = 3'd0; if1.acc_en = 1'b0;
    if1.acc_clear = 1'b0; if1.a = 1'b0; if1.b = 1'b0;
    s_iv = 1'b0; s_or = 1'b0; s_ae = 1'b0; s_ac = 1'b0; s_op = 3'd0; s_a = 8'h00; s_b = 8'h00;
  endtask

  task automatic apply_reset(input int cycles);
    reset = 1'b1;
    // Garbage on the inputs must be overridden by reset.
    if8.in_valid = 1'b1; if8.out_ready = 1'b1; if8.acc_clear = 1'b0; if8.acc_en = 1'b1;
    if8.a = 8'hC3; if8.op = 3'd1;
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0;
    idle_inputs();
    m_ov = 1'b0; m_res = 8'h00; m_zero = 1'b0; m_par = 1'b0; m_acc = 8'h00; m_cnt = 4'd0;
  endtask

  task automatic drive8(input logic iv, input logic orr, input int op, input logic ae,
                        input logic ac, input logic [7:0] a, input logic [7:0] b);
    s_iv = iv; s_or = orr; s_op = op[2:0]; s_ae = ae; s_ac = ac; s_a = a; s_b = b;
    if8.in_valid = iv; if8.out_ready = orr; if8.op = op[2:0]; if8.acc_en = ae;
    if8.acc_clear = ac; if8.a = a; if8.b = b;
    #1;
  endtask

  // Advance one clock and update the model from the spec's handshake rules.
  task automatic tick8();
    logic       acc_ok;
    logic [7:0] v;
    acc_ok = s_iv && (!m_ov || s_or);
    v = ref_op(s_op, s_a, s_ae ? m_acc : s_b);
    @(posedge clk);
    #1;
    if (acc_ok) begin
      m_res = v; m_zero = (v == 8'h00); m_par = ^v; m_ov = 1'b1; m_cnt = m_cnt + 4'd1;
      if (s_ae) m_acc = v;
    end else if (m_ov && s_or) begin
      m_ov = 1'b0;
    end
    if (s_ac) m_acc = 8'h00;
    if8.in_valid = 1'b0; if8.acc_clear = 1'b0; s_iv = 1'b0; s_ac = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset(2);
    nvec++; if (if8.out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid: got %b want 0", if8.out_valid); end
    nvec++; if (if8.result !== 8'h00) begin nerr++; $display("FAIL reset_result: got %h want 00", if8.result); end
    nvec++; if ({if8.zero, if8.parity} !== 2'b00) begin nerr++; $display("FAIL reset_flags: got %b want 00", {if8.zero, if8.parity}); end
    nvec++; if (if8.count !== 4'd0) begin nerr++; $display("FAIL reset_count: got %0d want 0", if8.count); end
    nvec++; if (if8.acc !== 8'h00) begin nerr++; $display("FAIL reset_acc: got %h want 00", if8.acc); end
    nvec++; if (if8.in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready: got %b want 1", if8.in_ready); end
    nvec++; if (if1.acc !== 1'b1) begin nerr++; $display("FAIL reset_acc_init: got %b want 1", if1.acc); end
  endtask

  task automatic test_truth_table();
    logic [3:0] row;
    for (int op = 0; op < 8; op++) begin
      for (int ab = 0; ab < 4; ab++) begin
        if1.in_valid = 1'b1; if1.out_ready = 1'b1; if1.acc_en = 1'b0;
        if1.op = op[2:0]; if1.a = ab[1]; if1.b = ab[0];
        @(posedge clk);
        #1;
        row = tt[op];
        nvec++;
        if (if1.out_valid !== 1'b1 || if1.result !== row[ab]) begin
          nerr++;
          $display("FAIL tt op=%0d a=%0d b=%0d: got valid=%b result=%b want 1/%b",
                   op, ab / 2, ab % 2, if1.out_valid, if1.result, row[ab]);
        end
      end
    end
    if1.in_valid = 1'b0;
    nvec++; if (if1.count !== 16'd32) begin nerr++; $display("FAIL tt_count: got %0d want 32", if1.count); end
    // Accumulate at WIDTH=1: acc starts at 1, XOR a=1 with acc gives 0 and loads acc.
    if1.in_valid = 1'b1; if1.op = 3'd5; if1.acc_en = 1'b1; if1.a = 1'b1; if1.b = 1'b1;
    @(posedge clk);
    #1;
    if1.in_valid = 1'b0; if1.acc_en = 1'b0;
    nvec++; if ({if1.result, if1.acc, if1.zero} !== 3'b001) begin nerr++; $display("FAIL w1_acc_xor: got res/acc/zero=%b%b%b want 001", if1.result, if1.acc, if1.zero); end
    if1.acc_clear = 1'b1;
    @(posedge clk);
    #1;
    if1.acc_clear = 1'b0;
    nvec++; if (if1.acc !== 1'b1) begin nerr++; $display("FAIL w1_acc_clear: got %b want 1", if1.acc); end
  endtask

  task automatic test_backpressure();
    drive8(1, 1, 0, 0, 0, 8'hF0, 8'h3C);
    tick8();
    nvec++; if ({if8.out_valid, if8.result, if8.zero, if8.parity} !== {1'b1, 8'h30, 1'b0, 1'b0}) begin
      nerr++; $display("FAIL bp_and: got v=%b r=%h z=%b p=%b want 1 30 0 0", if8.out_valid, if8.result, if8.zero, if8.parity);
    end
    for (int i = 0; i < 3; i++) begin
      drive8(1, 0, 5, 0, 0, 8'h55, 8'h0F);
      nvec++; if (if8.in_ready !== 1'b0) begin nerr++; $display("FAIL bp_in_ready cyc%0d: got %b want 0", i, if8.in_ready); end
      tick8();
      nvec++; if ({if8.out_valid, if8.result} !== {1'b1, 8'h30}) begin nerr++; $display("FAIL bp_hold cyc%0d: got v=%b r=%h want 1 30", i, if8.out_valid, if8.result); end
    end
    drive8(1, 1, 5, 0, 0, 8'h55, 8'h0F);
    nvec++; if (if8.in_ready !== 1'b1) begin nerr++; $display("FAIL bp_release_ready: got %b want 1", if8.in_ready); end
    tick8();
    nvec++; if ({if8.out_valid, if8.result, if8.count} !== {1'b1, 8'h5A, 4'd2}) begin
      nerr++; $display("FAIL bp_release: got v=%b r=%h cnt=%0d want 1 5a 2", if8.out_valid, if8.result, if8.count);
    end
  endtask

  task automatic test_accumulate();
    logic [7:0] exp_r [3] = '{8'h01, 8'h03, 8'h07};
    drive8(0, 1, 0, 0, 1, 8'h00, 8'h00);
    tick8();
    for (int i = 0; i < 3; i++) begin
      drive8(1, 1, 5, 1, 0, 8'h01 << i, 8'hFF);
      tick8();
      nvec++; if (if8.result !== exp_r[i]) begin nerr++; $display("FAIL acc_chain step%0d: got %h want %h", i, if8.result, exp_r[i]); end
    end
    nvec++; if (if8.acc !== 8'h07) begin nerr++; $display("FAIL acc_value: got %h want 07", if8.acc); end
    drive8(1, 1, 5, 1, 1, 8'h08, 8'hFF);
    tick8();
    nvec++; if ({if8.result, if8.acc} !== {8'h0F, 8'h00}) begin nerr++; $display("FAIL acc_clear_same_cycle: got r=%h acc=%h want 0f 00", if8.result, if8.acc); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      drive8(1, 1, i + 1, 0, 0, 8'h11 * i, 8'h96);
      tick8();
      nvec++;
      if ({if8.out_valid, if8.result, if8.zero, if8.parity, if8.count} !== {m_ov, m_res, m_zero, m_par, m_cnt}) begin
        nerr++; $display("FAIL b2b step%0d: got v=%b r=%h cnt=%0d want v=%b r=%h cnt=%0d",
                         i, if8.out_valid, if8.result, if8.count, m_ov, m_res, m_cnt);
      end
    end
  endtask

  task automatic test_counter_wrap();
    apply_reset(1);
    for (int i = 0; i < 17; i++) begin
      drive8(1, 1, 5, 0, 0, 8'hAA, 8'hAA);
      tick8();
    end
    nvec++; if (if8.count !== 4'd1) begin nerr++; $display("FAIL cnt_wrap: got %0d want 1", if8.count); end
    nvec++; if ({if8.result, if8.zero, if8.parity} !== {8'h00, 1'b1, 1'b0}) begin
      nerr++; $display("FAIL zero_flag: got r=%h z=%b p=%b want 00 1 0", if8.result, if8.zero, if8.parity);
    end
  endtask

  task automatic test_reset_mid();
    drive8(1, 1, 5, 1, 0, 8'h5A, 8'h00);
    tick8();
    drive8(1, 0, 0, 0, 0, 8'hFF, 8'h0F);
    tick8();
    nvec++; if ({if8.out_valid, if8.acc} !== {1'b1, 8'h5A}) begin nerr++; $display("FAIL mid_pre: got v=%b acc=%h want 1 5a", if8.out_valid, if8.acc); end
    apply_reset(1);
    nvec++; if ({if8.out_valid, if8.count, if8.acc, if8.result} !== {1'b0, 4'd0, 8'h00, 8'h00}) begin
      nerr++; $display("FAIL mid_reset: got v=%b cnt=%0d acc=%h r=%h want 0 0 00 00", if8.out_valid, if8.count, if8.acc, if8.result);
    end
  endtask

  task automatic test_random();
    logic want_rdy;
    for (int i = 0; i < 400; i++) begin
      drive8($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 7),
             $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0, 8'($urandom), 8'($urandom));
      want_rdy = !m_ov || s_or;
      nvec++; if (if8.in_ready !== want_rdy) begin nerr++; $display("FAIL rnd_in_ready cyc%0d: got %b want %b", i, if8.in_ready, want_rdy); end
      tick8();
      nvec++;
      if ({if8.out_valid, if8.result, if8.zero, if8.parity, if8.acc, if8.count} !==
          {m_ov, m_res, m_zero, m_par, m_acc, m_cnt}) begin
        nerr++; $display("FAIL rnd cyc%0d: got v=%b r=%h z=%b p=%b acc=%h cnt=%0d want v=%b r=%h z=%b p=%b acc=%h cnt=%0d",
                         i, if8.out_valid, if8.result, if8.zero, if8.parity, if8.acc, if8.count,
                         m_ov, m_res, m_zero, m_par, m_acc, m_cnt);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_truth_table();
    test_backpressure();
    test_accumulate();
    test_back_to_back();
    test_counter_wrap();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
